// File: rtl/ncl_pkg.sv
// Shared NCL definitions: rail encoding constants and a popcount helper.
// Latency: none (constants and pure functions only).
// Backpressure: not applicable.
package ncl_pkg;

  localparam logic NCL_NULL = 1'b0;
  localparam logic NCL_DATA = 1'b1;

  // Population count over a 32-bit vector; callers zero-extend narrower inputs.
  function automatic int unsigned ncl_popcount(input logic [31:0] v);
    int unsigned c;
    c = 0;
    for (int i = 0; i < 32; i++) begin
      c = c + {31'b0, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/ncl_thmn.sv
// Generic THmn threshold gate: sets at >= M inputs high, clears at none high, else holds.
// Latency: 1 clk from input sample to z; no combinational input-to-output path.
// Backpressure: none; samples a[] every rising edge.
module ncl_thmn
  import ncl_pkg::*;
#(
  parameter int N = 2,
  parameter int M = 1
) (
  input  logic         clk,
  input  logic         init,
  input  logic [N-1:0] a,
  output logic         z
);

  localparam int CW = $clog2(N + 1);

  logic [CW-1:0] cnt;
  logic          z_d;
  logic          z_q;

  // Count high inputs and apply the set/clear/hold hysteresis rule.
  always_comb begin
    cnt = CW'(ncl_popcount(32'(a)));
    z_d = z_q;
    if (cnt >= CW'(M)) begin
      z_d = NCL_DATA;
    end else if (cnt == '0) begin
      z_d = NCL_NULL;
    end
  end

  // State register; init forces NULL and overrides the threshold rule.
  always_ff @(posedge clk) begin
    if (init) begin
      z_q <= NCL_NULL;
    end else begin
      z_q <= z_d;
    end
  end

  assign z = z_q;

endmodule

// File: rtl/ncl_threshold_gates.sv
// LANES independent copies each of TH12, TH14 and TH22 registered NCL gates.
// Latency: 1 clk; outputs reflect inputs sampled at the previous rising edge.
// Backpressure: none; every lane samples its inputs each edge.
module ncl_threshold_gates
  import ncl_pkg::*;
#(
  parameter int LANES = 1
) (
  input  logic                 clk,
  input  logic                 init,
  input  logic [2*LANES-1:0]   th12_a,
  output logic [LANES-1:0]     th12_z,
  input  logic [4*LANES-1:0]   th14_a,
  output logic [LANES-1:0]     th14_z,
  input  logic [2*LANES-1:0]   th22_a,
  output logic [LANES-1:0]     th22_z
);

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    // Merge gate: registered 2-input OR.
    ncl_thmn #(.N(2), .M(1)) u_th12 (
      .clk  (clk),
      .init (init),
      .a    (th12_a[2*k +: 2]),
      .z    (th12_z[k])
    );

    // Completion gate: registered 4-input OR.
    ncl_thmn #(.N(4), .M(1)) u_th14 (
      .clk  (clk),
      .init (init),
      .a    (th14_a[4*k +: 4]),
      .z    (th14_z[k])
    );

    // Minterm gate: Muller C-element, holds with exactly one input high.
    ncl_thmn #(.N(2), .M(2)) u_th22 (
      .clk  (clk),
      .init (init),
      .a    (th22_a[2*k +: 2]),
      .z    (th22_z[k])
    );
  end

endmodule

// File: tb/tb_ncl_threshold_gates.sv
// Directed bench for ncl_threshold_gates with LANES=4 and a scoreboard queue.
// Lane 0 carries the directed sequences; other lanes get random or hold patterns.
module tb_ncl_threshold_gates;

  localparam int LANES = 4;
  localparam int W2    = 2 * LANES;
  localparam int W4    = 4 * LANES;

  logic             clk = 1'b0;
  logic             init;
  logic [W2-1:0]    th12_a;
  logic [W4-1:0]    th14_a;
  logic [W2-1:0]    th22_a;
  logic [LANES-1:0] th12_z;
  logic [LANES-1:0] th14_z;
  logic [LANES-1:0] th22_z;

  typedef struct packed {
    logic [LANES-1:0] z12;
    logic [LANES-1:0] z14;
    logic [LANES-1:0] z22;
  } exp_t;

  exp_t             sb[$];
  logic [LANES-1:0] m12 = '0;
  logic [LANES-1:0] m14 = '0;
  logic [LANES-1:0] m22 = '0;
  int               errors = 0;
  int               checks = 0;
  int               step_no = 0;

  always #5 clk = ~clk;

  ncl_threshold_gates #(.LANES(LANES)) dut (
    .clk    (clk),
    .init   (init),
    .th12_a (th12_a),
    .th12_z (th12_z),
    .th14_a (th14_a),
    .th14_z (th14_z),
    .th22_a (th22_a),
    .th22_z (th22_z)
  );

  // One directed step: drive inputs, update the reference model, push the
  // expectation, then after the edge pop it and compare all three gate types.
  task automatic step(input logic i, input logic fill, input logic [1:0] l12,
                      input logic [3:0] l14, input logic [1:0] l22);
    logic [W2-1:0] a12;
    logic [W4-1:0] a14;
    logic [W2-1:0] a22;
    logic [1:0]    p;
    exp_t          e;
    if (fill) begin
      a12 = '1;
      a14 = '1;
      a22 = '1;
    end else begin
      a12 = W2'($urandom);
      a14 = W4'($urandom);
      a22 = W2'($urandom);
      // Lane 2 TH22: assert early, then alternate 01/10 so it sits in hold.
      a22[5:4] = (step_no < 4) ? 2'b11 : (step_no[0] ? 2'b01 : 2'b10);
    end
    a12[1:0] = l12;
    a14[3:0] = l14;
    a22[1:0] = l22;
    init   = i;
    th12_a = a12;
    th14_a = a14;
    th22_a = a22;
    for (int k = 0; k < LANES; k++) begin
      if (i) begin
        m12[k] = 1'b0;
        m14[k] = 1'b0;
        m22[k] = 1'b0;
      end else begin
        m12[k] = a12[2*k] | a12[2*k+1];
        m14[k] = a14[4*k] | a14[4*k+1] | a14[4*k+2] | a14[4*k+3];
        p = a22[2*k +: 2];
        if (p == 2'b11)      m22[k] = 1'b1;
        else if (p == 2'b00) m22[k] = 1'b0;
      end
    end
    sb.push_back('{z12: m12, z14: m14, z22: m22});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    checks++;
    assert (th12_z === e.z12) else begin
      errors++;
      $error("FAIL th12 step=%0d observed=%b expected=%b", step_no, th12_z, e.z12);
    end
    checks++;
    assert (th14_z === e.z14) else begin
      errors++;
      $error("FAIL th14 step=%0d observed=%b expected=%b", step_no, th14_z, e.z14);
    end
    checks++;
    assert (th22_z === e.z22) else begin
      errors++;
      $error("FAIL th22 step=%0d observed=%b expected=%b", step_no, th22_z, e.z22);
    end
    step_no++;
  endtask

  initial begin
    init   = 1'b1;
    th12_a = '1;
    th14_a = '1;
    th22_a = '1;

    // Reset held with every input high: all outputs stay NULL.
    step(1'b1, 1'b1, 2'b11, 4'hF, 2'b11);
    step(1'b1, 1'b1, 2'b11, 4'hF, 2'b11);
    step(1'b1, 1'b1, 2'b11, 4'hF, 2'b11);
    // Release: everything asserts on the first free edge.
    step(1'b0, 1'b1, 2'b11, 4'hF, 2'b11);

    // Lane 0: TH12 00,01,10,11,00 / TH14 walking one / TH22 00,01,11,10,00,10,01.
    step(1'b0, 1'b0, 2'b00, 4'b0001, 2'b00);
    step(1'b0, 1'b0, 2'b01, 4'b0010, 2'b01);
    step(1'b0, 1'b0, 2'b10, 4'b0100, 2'b11);
    step(1'b0, 1'b0, 2'b11, 4'b1000, 2'b10);
    step(1'b0, 1'b0, 2'b00, 4'b0000, 2'b00);
    step(1'b0, 1'b0, 2'b01, 4'b1111, 2'b10);
    step(1'b0, 1'b0, 2'b00, 4'b0000, 2'b01);

    // Reset while TH22 holds 1 with one input high; stays 0 until 11.
    step(1'b0, 1'b0, 2'b00, 4'b0000, 2'b11);
    step(1'b0, 1'b0, 2'b00, 4'b0000, 2'b01);
    step(1'b1, 1'b0, 2'b00, 4'b0000, 2'b01);
    step(1'b0, 1'b0, 2'b00, 4'b0000, 2'b01);
    step(1'b0, 1'b0, 2'b00, 4'b0000, 2'b10);
    step(1'b0, 1'b0, 2'b00, 4'b0000, 2'b11);
    step(1'b0, 1'b0, 2'b00, 4'b0000, 2'b01);

    // Extra random traffic on the other lanes.
    for (int n = 0; n < 12; n++) begin
      step(1'b0, 1'b0, 2'($urandom), 4'($urandom), 2'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ncl_threshold_gates.md
# ncl_threshold_gates

Cycle-based model of the three NCL threshold gates used by the dual/multi-rail adder datapaths: TH12 (2-input, threshold 1), TH14 (4-input, threshold 1) and TH22 (2-input, threshold 2, Muller C-element). Each gate is a registered state element with NCL hysteresis:

- Output asserts (DATA) once at least M inputs are high.
- Output deasserts (NULL) only when all inputs are low.
- Otherwise the output holds.

The block sits under the rail-combining logic (minterm TH22s, merge TH12s, completion TH14s) so synchronous simulation and synthesis produce the same wavefronts as the asynchronous reference behaviour.

## Interface
- LANES, default 1: number of independent gate instances of each type; every port below is replicated per lane.
- clk  input  1  sampling clock; all state updates on rising edge.
- init  input  1  synchronous, active-high reset; forces every gate output to NULL (0).
- th12_a  input  2*LANES  TH12 inputs; lane k uses bits [2k+1:2k].
- th12_z  output  LANES  TH12 outputs.
- th14_a  input  4*LANES  TH14 inputs; lane k uses bits [4k+3:4k].
- th14_z  output  LANES  TH14 outputs.
- th22_a  input  2*LANES  TH22 inputs; lane k uses bits [2k+1:2k].
- th22_z  output  LANES  TH22 outputs.

## Operation
- Generic rule for a THmn gate with n inputs, threshold m, current output z, and cnt = number of inputs at 1:
  - z_next = 1 if cnt >= m.
  - z_next = 0 if cnt == 0.
  - z_next = z otherwise.
- TH12 (m=1, n=2):
  - 1 when either input is 1; 0 when both are 0.
  - No hold region exists, so it is a registered OR.
- TH14 (m=1, n=4):
  - 1 when any input is 1; 0 when all four are 0.
  - Registered 4-input OR.
- TH22 (m=2, n=2):
  - 1 when both inputs are 1; 0 when both are 0.
  - With exactly one input high it holds its previous value (C-element).
- All lanes and all gate types are fully independent; there is no cross-lane interaction.
- Counting uses a popcount sized ceil(log2(n+1)) bits. The comparisons cnt >= m and cnt == 0 are unsigned.
- Inputs may change arbitrarily between clocks; only the value sampled at the rising edge matters.
- There are no illegal input patterns. The NCL protocol (monotonic DATA/NULL wavefronts) is the environment's responsibility, not checked here.

## Timing
- Latency is 1 clock: the output reflects inputs sampled at the previous rising edge.
- Reset:
  - When init = 1 at a rising edge, th12_z, th14_z and th22_z all become 0 on that edge, regardless of inputs.
  - Reset has priority over the threshold rule.
  - While init stays high, outputs remain 0.
- Reset release: on the first edge with init = 0, each output evaluates from its 0 state. A TH22 with one input high therefore stays 0.
- Reset mid-operation: a TH22 holding 1 with one input high is cleared to 0 by init and stays 0 after release until both inputs are 1.
- Simultaneous events:
  - For TH22, an input pattern moving directly from 01 to 10 in one sample holds the output, since cnt = 1.
  - 00 to 11 asserts; 11 to 00 deasserts.
- No combinational path exists from any input to any output.

## Structure
- One generic sub-module, `ncl_thmn`:
  - Parameters N (input count) and M (threshold).
  - Ports clk, init, a[N-1:0], z.
  - Implements popcount plus the set/clear/hold register.
- The top level instantiates ncl_thmn in generate loops over LANES: N=2/M=1, N=4/M=1, N=2/M=2.
- Shared package (ncl_pkg) holds:
  - the NULL/DATA rail encoding constants (NCL_NULL = 1'b0, NCL_DATA = 1'b1);
  - a popcount function reused by other NCL blocks.

## Test plan
- Reset: drive all inputs 1 with init = 1 for 3 cycles. Require all outputs 0 each cycle. Release init, and all outputs = 1 on the next edge.
- TH22 hysteresis:
  - Sequence a = 00, 01, 11, 10, 00, 10, 01.
  - Required th22_z (one cycle later) = 0, 0, 1, 1, 0, 0, 0.
- TH12:
  - Sequence a = 00, 01, 10, 11, 00.
  - Required th12_z = 0, 1, 1, 1, 0.
- TH14:
  - Walk a single 1 across bits 0..3, then 0000.
  - Required th14_z = 1, 1, 1, 1, 0. Also 1111 gives 1.
- Reset mid-hold: TH22 at 1 with a = 01, then assert init for one cycle. Require z = 0, and it stays 0 with a = 01 after release until a = 11.
- Lanes (LANES = 4): drive distinct patterns per lane, including TH22 lane 2 in hold. Require each lane to match an independent reference model, with no cross-talk.
